// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU control unit, the program counter block and its bench:
// the default widths and the op-priority encoding.
package cpu_pkg;

    localparam int DEFAULT_PC_WIDTH  = 8;
    localparam int DEFAULT_BUS_WIDTH = 16;

    // Listed from lowest to highest priority.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_COUNT,
        OP_BRANCH,
        OP_JUMP,
        OP_RETURN,
        OP_CALL
    } op_e;

    // Reduces the strobes to the single op that takes effect.
    function automatic op_e decode_op(
        input logic call,
        input logic ret,
        input logic jump,
        input logic branch,
        input logic count
    );
        if (call)        return OP_CALL;
        else if (ret)    return OP_RETURN;
        else if (jump)   return OP_JUMP;
        else if (branch) return OP_BRANCH;
        else if (count)  return OP_COUNT;
        else             return OP_NONE;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Flop-based LIFO of return addresses. The write pointer is the entry count,
// and the top entry is read combinationally.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_m1;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign count_m1 = count - CNT_W'(1);
    assign wr_idx   = count[IDX_W-1:0];
    assign rd_idx   = count_m1[IDX_W-1:0];

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign top   = empty ? '0 : mem[rd_idx];

    // The caller never pushes while full or pops while empty, and never does both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count_m1;
        end
    end

    // Entry contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with relative branches and a hardware call/return stack.
// The block drives its PC onto the shared tri-state bus on request.
module program_counter_stack
    import cpu_pkg::*;
#(
    parameter  int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter  int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    inout  wire  [BUS_WIDTH-1:0] Bus,
    input  logic                 ProgramCounterOut,
    input  logic                 CountEnable,
    input  logic                 Jump,
    input  logic                 Branch,
    input  logic                 Call,
    input  logic                 Return,
    input  logic                 ClearFlags,
    output logic [PC_WIDTH-1:0]  Pc,
    output logic [DEPTH_W-1:0]   StackCount,
    output logic                 StackEmpty,
    output logic                 StackFull,
    output logic                 StackOverflow,
    output logic                 StackUnderflow
);

    op_e                 op;
    logic [PC_WIDTH-1:0] bus_in;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] stack_top;
    logic                push;
    logic                pop;
    logic                set_ovf;
    logic                set_unf;
    logic                unused_bus_bits;

    assign Bus             = ProgramCounterOut ? BUS_WIDTH'(Pc) : {BUS_WIDTH{1'bz}};
    assign bus_in          = Bus[PC_WIDTH-1:0];
    assign unused_bus_bits = ^Bus;

    assign op       = decode_op(Call, Return, Jump, Branch, CountEnable);
    assign pc_plus1 = Pc + PC_WIDTH'(1);

    always_comb begin
        pc_next = Pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            OP_CALL: begin
                if (!StackFull) begin
                    push    = 1'b1;
                    pc_next = bus_in;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            OP_RETURN: begin
                if (!StackEmpty) begin
                    pop     = 1'b1;
                    pc_next = stack_top;
                end else begin
                    set_unf = 1'b1;
                end
            end
            OP_JUMP:   pc_next = bus_in;
            // Same-width modular add equals adding the sign-extended offset.
            OP_BRANCH: pc_next = Pc + bus_in;
            OP_COUNT:  pc_next = pc_plus1;
            default:   pc_next = Pc;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Pc <= '0;
        end else begin
            Pc <= pc_next;
        end
    end

    // Sticky flags: a new error on the same edge as ClearFlags keeps the flag set.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StackOverflow  <= 1'b0;
            StackUnderflow <= 1'b0;
        end else begin
            if (set_ovf)         StackOverflow <= 1'b1;
            else if (ClearFlags) StackOverflow <= 1'b0;
            if (set_unf)         StackUnderflow <= 1'b1;
            else if (ClearFlags) StackUnderflow <= 1'b0;
        end
    end

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH),
        .CNT_W (DEPTH_W)
    ) u_stack (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (stack_top),
        .count     (StackCount),
        .full      (StackFull),
        .empty     (StackEmpty)
    );

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: a count run, a vector table for
// jump/branch/call/return/flag behaviour, then hand-written multi-cycle cases.
module tb_program_counter_stack;
    import cpu_pkg::*;

    localparam int PW = 8;
    localparam int BW = 16;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    // ops bit order: {call, ret, jump, branch, count, clear}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_CALL = 6'b100000;
    localparam logic [5:0] O_RET  = 6'b010000;
    localparam logic [5:0] O_JMP  = 6'b001000;
    localparam logic [5:0] O_BR   = 6'b000100;
    localparam logic [5:0] O_CNT  = 6'b000010;
    localparam logic [5:0] O_CLR  = 6'b000001;

    typedef struct {
        logic [5:0]    ops;
        logic [BW-1:0] bus;
        logic [PW-1:0] pc;
        logic [DW-1:0] cnt;
        logic          ovf;
        logic          unf;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    wire  [BW-1:0] Bus;
    logic          ProgramCounterOut = 1'b0;
    logic          CountEnable = 1'b0;
    logic          Jump = 1'b0;
    logic          Branch = 1'b0;
    logic          Call = 1'b0;
    logic          Return = 1'b0;
    logic          ClearFlags = 1'b0;
    logic [PW-1:0] Pc;
    logic [DW-1:0] StackCount;
    logic          StackEmpty;
    logic          StackFull;
    logic          StackOverflow;
    logic          StackUnderflow;

    logic          drv_en = 1'b0;
    logic [BW-1:0] drv_val = '0;
    int            checks = 0;
    int            errors = 0;
    vec_t          vecs[$];

    assign Bus = drv_en ? drv_val : {BW{1'bz}};

    always #5 Clk = ~Clk;

    program_counter_stack #(
        .PC_WIDTH    (PW),
        .BUS_WIDTH   (BW),
        .STACK_DEPTH (SD)
    ) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .Bus               (Bus),
        .ProgramCounterOut (ProgramCounterOut),
        .CountEnable       (CountEnable),
        .Jump              (Jump),
        .Branch            (Branch),
        .Call              (Call),
        .Return            (Return),
        .ClearFlags        (ClearFlags),
        .Pc                (Pc),
        .StackCount        (StackCount),
        .StackEmpty        (StackEmpty),
        .StackFull         (StackFull),
        .StackOverflow     (StackOverflow),
        .StackUnderflow    (StackUnderflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [PW-1:0] pc, input logic [DW-1:0] cnt,
                               input logic ovf, input logic unf);
        check({tag, " pc"}, 32'(Pc), 32'(pc));
        check({tag, " count"}, 32'(StackCount), 32'(cnt));
        check({tag, " empty"}, 32'(StackEmpty), 32'(cnt == 0));
        check({tag, " full"}, 32'(StackFull), 32'(cnt == DW'(SD)));
        check({tag, " ovf"}, 32'(StackOverflow), 32'(ovf));
        check({tag, " unf"}, 32'(StackUnderflow), 32'(unf));
    endtask

    task automatic set_ops(input logic [5:0] ops);
        {Call, Return, Jump, Branch, CountEnable, ClearFlags} = ops;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] ops, input logic [BW-1:0] bus, input logic [PW-1:0] pc,
                                input logic [DW-1:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.ops = ops; v.bus = bus; v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        // Table entries continue from Pc=0x2C, empty stack, flags clear.
        vecs.push_back(mk(O_JMP,                 16'h0040, 8'h40, 0, 0, 0));
        vecs.push_back(mk(O_BR,                  16'h00FE, 8'h3E, 0, 0, 0));
        vecs.push_back(mk(O_BR,                  16'h0005, 8'h43, 0, 0, 0));
        vecs.push_back(mk(O_JMP,                 16'h0010, 8'h10, 0, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0020, 8'h20, 1, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0030, 8'h30, 2, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0040, 8'h40, 3, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h31, 2, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h21, 1, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h11, 0, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0050, 8'h50, 1, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0060, 8'h60, 2, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0070, 8'h70, 3, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0080, 8'h80, 4, 0, 0));
        vecs.push_back(mk(O_CALL,                16'h0099, 8'h80, 4, 1, 0));
        vecs.push_back(mk(O_CNT | O_CLR,         16'h0000, 8'h81, 4, 0, 0));
        vecs.push_back(mk(O_CALL | O_CLR,        16'h00A0, 8'h81, 4, 1, 0));
        vecs.push_back(mk(O_CLR,                 16'h0000, 8'h81, 4, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h71, 3, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h61, 2, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h51, 1, 0, 0));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h12, 0, 0, 0));
        vecs.push_back(mk(O_JMP,                 16'h0005, 8'h05, 0, 0, 0));
        vecs.push_back(mk(O_RET | O_CNT,         16'h0000, 8'h05, 0, 0, 1));
        vecs.push_back(mk(O_CALL | O_JMP | O_CNT, 16'h0070, 8'h70, 1, 0, 1));
        vecs.push_back(mk(O_RET,                 16'h0000, 8'h06, 0, 0, 1));
        vecs.push_back(mk(O_CLR,                 16'h0000, 8'h06, 0, 0, 0));
        vecs.push_back(mk(O_BR | O_CNT,          16'h00FF, 8'h05, 0, 0, 0));
        vecs.push_back(mk(O_NONE,                16'h0000, 8'h05, 0, 0, 0));

        // Reset values, checked before any clock edge.
        #1 Rst_n = 1'b0;
        #2;
        check_state("reset", 8'h00, 0, 0, 0);

        // Count run: 300 increments wrap through 0xFF -> 0x00 and end at 0x2C.
        @(negedge Clk);
        Rst_n = 1'b1;
        CountEnable = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            check($sformatf("count pc[%0d]", i), 32'(Pc), 32'(i % 256));
            if (Pc != 0) check("bus idle", 32'(Bus === {8'h00, Pc}), 32'(0));
        end
        CountEnable = 1'b0;
        check_state("count end", 8'h2C, 0, 0, 0);

        // Bus drive is combinational.
        ProgramCounterOut = 1'b1;
        #1 check("bus drive", 32'(Bus), 32'h002C);
        ProgramCounterOut = 1'b0;
        #1;

        drv_en = 1'b1;
        foreach (vecs[i]) begin
            set_ops(vecs[i].ops);
            drv_val = vecs[i].bus;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end
        set_ops(O_NONE);
        drv_en = 1'b0;

        // Degenerate Jump reading the block's own PC drive holds Pc.
        $display("warning: Jump sampled while ProgramCounterOut=1 (degenerate)");
        ProgramCounterOut = 1'b1;
        Jump = 1'b1;
        step();
        Jump = 1'b0;
        ProgramCounterOut = 1'b0;
        check_state("self jump", 8'h05, 0, 0, 0);

        // Set underflow, push two entries, then reset asynchronously between edges.
        Return = 1'b1;
        step();
        Return = 1'b0;
        drv_en = 1'b1;
        drv_val = 16'h0030;
        Call = 1'b1;
        step();
        drv_val = 16'h0040;
        step();
        Call = 1'b0;
        drv_en = 1'b0;
        check_state("pre reset", 8'h40, 2, 0, 1);
        #2 Rst_n = 1'b0;
        #1 check_state("async reset", 8'h00, 0, 0, 0);

        // Release with CountEnable held: counting resumes from 0 on the following edges.
        @(negedge Clk);
        Rst_n = 1'b1;
        CountEnable = 1'b1;
        step();
        CountEnable = 1'b0;
        check_state("post reset count", 8'h01, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised successor to the 8-bit program counter. It adds configurable PC and bus width, relative branches, and a hardware call/return stack with depth reporting and sticky error flags. It sits on the shared tri-state CPU bus. The control unit drives one-hot-ish op strobes each cycle; the block drives its PC onto the bus on request.

Parameters:
PC_WIDTH, 8, width of the program counter; must be <= BUS_WIDTH
BUS_WIDTH, 16, width of the shared tri-state bus
STACK_DEPTH, 4, number of return-address entries; must be >= 1
DEPTH_W, $clog2(STACK_DEPTH+1), width of the StackCount output (derived, not overridden)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Bus  inout  BUS_WIDTH  shared CPU bus
ProgramCounterOut  input  1  drive {zeros, Pc} onto Bus
CountEnable  input  1  increment PC
Jump  input  1  load PC from Bus[PC_WIDTH-1:0]
Branch  input  1  add signed Bus[PC_WIDTH-1:0] to PC
Call  input  1  push PC+1, then load PC from Bus
Return  input  1  pop top of stack into PC
ClearFlags  input  1  clear sticky error flags
Pc  output  PC_WIDTH  current PC (registered)
StackCount  output  DEPTH_W  number of valid stack entries
StackEmpty  output  1  StackCount == 0
StackFull  output  1  StackCount == STACK_DEPTH
StackOverflow  output  1  sticky: Call attempted while full
StackUnderflow  output  1  sticky: Return attempted while empty

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Rst_n, and is applied immediately regardless of Clk.
- Reset values: Pc=0, StackCount=0, StackEmpty=1, StackFull=0, both flags=0. Stack RAM contents are don't-care.
- Bus drive:
  - Bus = {(BUS_WIDTH-PC_WIDTH)'b0, Pc} while ProgramCounterOut=1; otherwise high-Z.
  - Combinational, zero latency.
- Op priority, evaluated each rising edge: Call > Return > Jump > Branch > CountEnable. Only the highest asserted op takes effect. No op asserted: PC holds.
- Call:
  - Not full: stack[StackCount] <= Pc+1 (mod 2^PC_WIDTH); StackCount++; Pc <= Bus[PC_WIDTH-1:0].
  - Full: Pc and stack unchanged; StackOverflow <= 1.
- Return:
  - Not empty: Pc <= stack[StackCount-1]; StackCount--.
  - Empty: Pc unchanged; StackUnderflow <= 1.
- Jump: Pc <= Bus[PC_WIDTH-1:0].
- Branch: Pc <= Pc + sign-extended Bus[PC_WIDTH-1:0], mod 2^PC_WIDTH. The offset is relative to the current Pc, not Pc+1.
- CountEnable: Pc <= Pc+1. Wraps from all-ones to 0 with no flag.
- Latency: all PC and stack updates are visible on Pc/StackCount one cycle after the op edge.
- Flags:
  - StackOverflow and StackUnderflow are sticky. ClearFlags clears them the next edge.
  - A flag set and ClearFlags on the same edge: set wins.
  - Flags never alter Pc.
- Load ops with ProgramCounterOut=1: a load op (Jump/Branch/Call) sampled while ProgramCounterOut=1 reads the block's own drive. This is legal but degenerate: Jump holds Pc; Call pushes Pc+1 and reloads Pc. The bench flags it as a warning, not an error.
- Stack storage: flop array, write pointer = StackCount. No RAM read latency; the top entry is read combinationally.
- Reset mid-operation: Rst_n low asynchronously forces the reset values. An op strobed on the edge coinciding with reset release is ignored.

Decomposition:
- Shared package cpu_pkg:
  - localparams for default PC_WIDTH/BUS_WIDTH.
  - An op-priority enum (OP_NONE, OP_COUNT, OP_BRANCH, OP_JUMP, OP_RETURN, OP_CALL) for the control unit and bench to share.
- One sub-module: return_stack (parametrised LIFO with push, pop, count, full/empty, and top-of-stack read).
- The PC register, next-PC mux, bus driver and flags stay in program_counter_stack.

Test Plan:
- Reset and count: release Rst_n, CountEnable for 300 cycles, PC_WIDTH=8 -> Pc passes 0xFF then 0x00 at cycle 256, ends at 0x2C (300 mod 256); Bus high-Z throughout.
- Jump and branch: Bus=0x0040 with Jump -> Pc=0x40. Then Bus=0x00FE (-2) with Branch -> Pc=0x3E. Then Bus=0x0005 with Branch -> Pc=0x43. ProgramCounterOut=1 -> Bus=0x0043.
- Nested call/return, STACK_DEPTH=4: Pc=0x10, Call to 0x20, 0x30, 0x40 -> StackCount=3. Three Returns -> Pc sequence 0x31, 0x21, 0x11; StackEmpty=1.
- Overflow: fill with 4 Calls, then Call to 0x99 -> Pc unchanged, StackCount=4, StackOverflow=1. ClearFlags -> flag 0.
- Underflow and priority: empty stack, Return with CountEnable at Pc=0x05 -> Pc stays 0x05, StackUnderflow=1. Next, Call+Jump+CountEnable with Bus=0x0070 -> Call taken: Pc=0x70, stack top=0x06.
- Async reset mid-call: assert Rst_n low between edges with StackCount=2 -> Pc=0, StackCount=0, flags 0 immediately, without waiting for a Clk edge.
